// File: rtl/checkpoint_rollback_ctrl.sv
// Checkpoint/rollback initiator: in-order speculation buffer issuing release/rollback commands to the RF.
// Optional macro CHKCTRL_RES_BYPASS_EN lets a head resolution raise its command in the same cycle.
module checkpoint_rollback_ctrl #(
    parameter int chk_width  = 1,
    parameter int spec_width = 2,
    localparam int depth     = 2 ** spec_width
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ALLOC_E,
    input  logic [chk_width-1:0]  CHK_IN,
    output logic                  ALLOC_READY,
    output logic [spec_width-1:0] SPEC_ID,
    input  logic                  RES_E,
    input  logic [spec_width-1:0] RES_ID,
    input  logic                  RES_MISPRED,
    output logic [chk_width-1:0]  ROLLBK_OUT,
    output logic                  DO_ROLL,
    output logic                  DO_REL,
    output logic                  ROLLBK_E,
    input  logic                  ROLLBK_READY,
    output logic                  FLUSH,
    output logic                  EMPTY
);

    // Command handshake: ROLLBK_E is valid, ROLLBK_READY is ready; the command fires on
    // ROLLBK_E & ROLLBK_READY and ROLLBK_E/ROLLBK_OUT/DO_* hold steady until it does.

    localparam logic [spec_width:0] full_count = (spec_width + 1)'(depth);

    logic [spec_width-1:0] head;
    logic [spec_width-1:0] tail;
    logic [spec_width:0]   count;
    logic [depth-1:0]      valid_q;
    logic [depth-1:0]      resolved_q;
    logic [depth-1:0]      mispred_q;
    logic [chk_width-1:0]  chk_q [depth];

    logic head_done;
    logic bypass_hit;
    logic cmd_mispred;
    logic fire;
    logic rel_fire;
    logic roll_fire;
    logic alloc_fire;
    logic res_ok;

    always_comb begin
        head_done = valid_q[head] & resolved_q[head];
`ifdef CHKCTRL_RES_BYPASS_EN
        bypass_hit = RES_E & (RES_ID == head) & valid_q[head] & ~resolved_q[head];
`else
        bypass_hit = 1'b0;
`endif
        // A recorded outcome takes precedence; only the bypass path looks at the live input.
        cmd_mispred = head_done ? mispred_q[head] : RES_MISPRED;
        ROLLBK_E    = head_done | bypass_hit;
        DO_ROLL     = ROLLBK_E & cmd_mispred;
        DO_REL      = ROLLBK_E & ~cmd_mispred;
        ROLLBK_OUT  = chk_q[head];
        fire        = ROLLBK_E & ROLLBK_READY;
        roll_fire   = fire & cmd_mispred;
        rel_fire    = fire & ~cmd_mispred;
        ALLOC_READY = (count != full_count) & ~roll_fire;
        alloc_fire  = ALLOC_E & ALLOC_READY;
        res_ok      = RES_E & valid_q[RES_ID] & ~resolved_q[RES_ID];
        FLUSH       = roll_fire;
        EMPTY       = (count == '0);
        SPEC_ID     = tail;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            valid_q    <= '0;
            resolved_q <= '0;
            mispred_q  <= '0;
            for (int i = 0; i < depth; i++) chk_q[i] <= '0;
        end else begin
            if (res_ok) begin
                resolved_q[RES_ID] <= 1'b1;
                mispred_q[RES_ID]  <= RES_MISPRED;
            end
            if (rel_fire) begin
                valid_q[head]    <= 1'b0;
                resolved_q[head] <= 1'b0;
                head             <= head + 1'b1;
            end
            // When full, head and tail coincide but alloc is blocked, so these never collide.
            if (alloc_fire) begin
                chk_q[tail]      <= CHK_IN;
                valid_q[tail]    <= 1'b1;
                resolved_q[tail] <= 1'b0;
                mispred_q[tail]  <= 1'b0;
                tail             <= tail + 1'b1;
            end
            case ({alloc_fire, rel_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Rollback squashes everything, overriding any resolution recorded this cycle.
            if (roll_fire) begin
                valid_q    <= '0;
                resolved_q <= '0;
                mispred_q  <= '0;
                head       <= tail;
                count      <= '0;
            end
        end
    end

endmodule
